// File: rtl/game_pkg.sv
// Shared board geometry, collision-state bit positions and checker FSM encoding.
package game_pkg;

    localparam int unsigned FRAC_BITS  = 8;
    localparam int unsigned BOARD_W    = 640;
    localparam int unsigned BOARD_H    = 480;
    localparam int unsigned TANK_W     = 16;
    localparam int unsigned TANK_H     = 8;
    localparam int unsigned ARM_CHECKS = 4;

    localparam int unsigned CS_TANK0   = 3;
    localparam int unsigned CS_TANK1   = 2;
    localparam int unsigned CS_TERRAIN = 1;
    localparam int unsigned CS_INB     = 0;

    // In-bounds with nothing hit; an all-zero code would read as a collision downstream.
    localparam logic [3:0] CS_NONE = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWait,
        StCmp,
        StDone
    } cc_state_e;

endpackage

// File: rtl/hitbox_cmp.sv
// Combinational point-in-box test; box end coordinates are formed in 11 bits so they never wrap.
module hitbox_cmp #(
    parameter int unsigned W = 16,
    parameter int unsigned H = 8
) (
    input  logic [9:0] px_i,
    input  logic [9:0] py_i,
    input  logic [9:0] box_x_i,
    input  logic [9:0] box_y_i,
    output logic       hit_o
);

    logic [10:0] x_end;
    logic [10:0] y_end;

    always_comb begin
        x_end = {1'b0, box_x_i} + 11'(W);
        y_end = {1'b0, box_y_i} + 11'(H);
        hit_o = (px_i >= box_x_i) && ({1'b0, px_i} < x_end) &&
                (py_i >= box_y_i) && ({1'b0, py_i} < y_end);
    end

endmodule

// File: rtl/collision_checker.sv
// Shell collision checker: pixel conversion, terrain ROM fetch, tank hitbox and bounds tests,
// publishing a held 4-bit collision state with a one-cycle valid pulse.
module collision_checker
    import game_pkg::*;
(
    input  logic        clock_50m,
    input  logic        rst_n,
    input  logic        check_req,
    input  logic        arm,
    input  logic        shooter_id,
    input  logic [17:0] pos_x,
    input  logic [17:0] pos_y,
    input  logic [9:0]  tank0_x,
    input  logic [9:0]  tank0_y,
    input  logic [9:0]  tank1_x,
    input  logic [9:0]  tank1_y,
    output logic [9:0]  terrain_addr,
    input  logic [8:0]  terrain_q,
    output logic        busy,
    output logic        check_valid,
    output logic [3:0]  clide_state
);

    localparam logic [9:0] XMax = 10'(BOARD_W - 1);

    cc_state_e  state_q;
    logic [9:0] x_pix_q;
    logic [9:0] y_pix_q;
    logic [9:0] terrain_addr_q;
    logic       busy_q;
    logic       check_valid_q;
    logic [3:0] clide_state_q;
    logic [2:0] mask_cnt_q;
    logic       shooter_q;

    logic       hit0;
    logic       hit1;
    logic       inb;
    logic       masked;
    logic [3:0] flags;

    hitbox_cmp #(
        .W (TANK_W),
        .H (TANK_H)
    ) u_hit_tank0 (
        .px_i    (x_pix_q),
        .py_i    (y_pix_q),
        .box_x_i (tank0_x),
        .box_y_i (tank0_y),
        .hit_o   (hit0)
    );

    hitbox_cmp #(
        .W (TANK_W),
        .H (TANK_H)
    ) u_hit_tank1 (
        .px_i    (x_pix_q),
        .py_i    (y_pix_q),
        .box_x_i (tank1_x),
        .box_y_i (tank1_y),
        .hit_o   (hit1)
    );

    // Every flag is gated by inb so an out-of-bounds shell always reports 4'b0000.
    always_comb begin
        inb    = (x_pix_q < 10'(BOARD_W)) && (y_pix_q < 10'(BOARD_H));
        masked = mask_cnt_q < 3'(ARM_CHECKS);
        flags  = '0;
        flags[CS_INB]     = inb;
        flags[CS_TERRAIN] = inb && (y_pix_q >= {1'b0, terrain_q});
        flags[CS_TANK0]   = inb && hit0 && !(masked && !shooter_q);
        flags[CS_TANK1]   = inb && hit1 && !(masked && shooter_q);
    end

    always_ff @(posedge clock_50m) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            x_pix_q        <= '0;
            y_pix_q        <= '0;
            terrain_addr_q <= '0;
            busy_q         <= 1'b0;
            check_valid_q  <= 1'b0;
            clide_state_q  <= CS_NONE;
            mask_cnt_q     <= '0;
            shooter_q      <= 1'b0;
        end else begin
            check_valid_q <= 1'b0;

            // A launch in the same cycle as DONE restarts the mask rather than counting.
            if (arm) begin
                mask_cnt_q <= '0;
                shooter_q  <= shooter_id;
            end else if (state_q == StDone && mask_cnt_q < 3'(ARM_CHECKS)) begin
                mask_cnt_q <= mask_cnt_q + 3'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (check_req) begin
                        x_pix_q <= pos_x[FRAC_BITS+:10];
                        y_pix_q <= pos_y[FRAC_BITS+:10];
                        busy_q  <= 1'b1;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    terrain_addr_q <= (x_pix_q > XMax) ? XMax : x_pix_q;
                    state_q        <= StWait;
                end
                StWait: begin
                    state_q <= StCmp;
                end
                StCmp: begin
                    // ROM data is valid here; the result is visible during DONE.
                    clide_state_q <= flags;
                    check_valid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign terrain_addr = terrain_addr_q;
    assign busy         = busy_q;
    assign check_valid  = check_valid_q;
    assign clide_state  = clide_state_q;

endmodule

// File: tb/tb_collision_checker.sv
// Directed bench for collision_checker with a one-cycle-latency terrain ROM model.
module tb_collision_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        check_req;
    logic        arm;
    logic        shooter_id;
    logic [17:0] pos_x;
    logic [17:0] pos_y;
    logic [9:0]  tank0_x;
    logic [9:0]  tank0_y;
    logic [9:0]  tank1_x;
    logic [9:0]  tank1_y;
    logic [9:0]  terrain_addr;
    logic [8:0]  terrain_q;
    logic        busy;
    logic        check_valid;
    logic [3:0]  clide_state;
    logic [8:0]  terrain_val;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    always @(posedge clk) terrain_q <= terrain_val;

    collision_checker dut (
        .clock_50m    (clk),
        .rst_n        (rst_n),
        .check_req    (check_req),
        .arm          (arm),
        .shooter_id   (shooter_id),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .tank0_x      (tank0_x),
        .tank0_y      (tank0_y),
        .tank1_x      (tank1_x),
        .tank1_y      (tank1_y),
        .terrain_addr (terrain_addr),
        .terrain_q    (terrain_q),
        .busy         (busy),
        .check_valid  (check_valid),
        .clide_state  (clide_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Fractional bits are non-zero to confirm they are dropped.
    task automatic run_check(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [3:0] exp);
        int lat;
        pos_x = {x, 8'h9c};
        pos_y = {y, 8'h41};
        @(negedge clk) check_req = 1'b1;
        @(negedge clk) check_req = 1'b0;
        check_eq({tag, "/busy"}, busy, 1);
        lat = 0;
        while (!check_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "/latency"}, lat, 3);
        check_eq({tag, "/state"}, clide_state, exp);
        check_eq({tag, "/busy_done"}, busy, 0);
        @(negedge clk);
        check_eq({tag, "/pulse"}, check_valid, 0);
    endtask

    task automatic do_arm(input logic sid);
        @(negedge clk);
        arm        = 1'b1;
        shooter_id = sid;
        @(negedge clk);
        arm = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        logic [11:0] pat;
        rst_n       = 1'b0;
        check_req   = 1'b0;
        arm         = 1'b0;
        shooter_id  = 1'b0;
        pos_x       = '0;
        pos_y       = '0;
        tank0_x     = 10'd0;
        tank0_y     = 10'd0;
        tank1_x     = 10'd500;
        tank1_y     = 10'd0;
        terrain_val = 9'd400;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst/state", clide_state, 4'b0001);
        check_eq("rst/busy", busy, 0);
        check_eq("rst/valid", check_valid, 0);
        check_eq("rst/addr", terrain_addr, 0);
        rst_n = 1'b1;

        // Clear air and terrain
        run_check("clear", 10'd100, 10'd50, 4'b0001);
        check_eq("clear/addr", terrain_addr, 100);
        run_check("terrain", 10'd200, 10'd410, 4'b0011);
        check_eq("terrain/addr", terrain_addr, 200);
        run_check("terrain399", 10'd200, 10'd399, 4'b0001);

        // Tank1 hit; shooter is tank0 (masked but not involved)
        tank1_x = 10'd300;
        tank1_y = 10'd380;
        run_check("tank1", 10'd315, 10'd387, 4'b0101);
        run_check("tank1_edge", 10'd316, 10'd387, 4'b0001);

        // Tank1 fires: own hit masked for four checks
        do_arm(1'b1);
        for (int i = 1; i <= 4; i++)
            run_check($sformatf("mask%0d", i), 10'd315, 10'd387, 4'b0001);
        run_check("mask5", 10'd315, 10'd387, 4'b0101);

        // Tank0 overlapping terrain
        tank0_x = 10'd200;
        tank0_y = 10'd400;
        run_check("tank0_terr", 10'd205, 10'd405, 4'b1011);
        do_arm(1'b0);
        run_check("tank0_masked", 10'd205, 10'd405, 4'b0011);

        // Bounds
        run_check("x640", 10'd640, 10'd50, 4'b0000);
        check_eq("x640/addr", terrain_addr, 639);
        run_check("y480", 10'd100, 10'd480, 4'b0000);

        // Requests while busy are dropped
        pos_x = {10'd100, 8'h00};
        pos_y = {10'd50, 8'h00};
        pat   = 12'b0000_0000_1011;
        nv    = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nv += int'(check_valid);
            check_req = pat[i];
        end
        check_req = 1'b0;
        check_eq("busy_req/valids", nv, 1);
        check_eq("busy_req/state", clide_state, 4'b0001);

        // Reset mid-check suppresses the result; start from a 0000 state
        run_check("pre_rst", 10'd100, 10'd480, 4'b0000);
        pos_y = {10'd480, 8'h00};
        nv    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nv += int'(check_valid);
            check_req = (i == 0);
            rst_n     = !(i == 2);
        end
        check_eq("midrst/valids", nv, 0);
        check_eq("midrst/state", clide_state, 4'b0001);
        check_eq("midrst/busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
